// File: rtl/param_reg_file_if.sv
// param_reg_file_if: write/read/clear bundle for param_reg_file.
// master drives clear, write_*, read_address_*; slave returns read_data_*, ready, write_error.
interface param_reg_file_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    logic                  clear;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [WIDTH-1:0]      write_data;
    logic [ADDR_WIDTH-1:0] read_address_0;
    logic [ADDR_WIDTH-1:0] read_address_1;
    logic [WIDTH-1:0]      read_data_0;
    logic [WIDTH-1:0]      read_data_1;
    logic                  ready;
    logic                  write_error;

    modport master (
        output clear, write_enable, write_address, write_data,
        output read_address_0, read_address_1,
        input  read_data_0, read_data_1, ready, write_error
    );

    modport slave (
        input  clear, write_enable, write_address, write_data,
        input  read_address_0, read_address_1,
        output read_data_0, read_data_1, ready, write_error
    );
endinterface

// File: rtl/param_reg_file.sv
// param_reg_file: DEPTH x WIDTH register file, one write port, two registered
// read ports, init sweep to INIT_VALUE after reset/clear, write bypass, write_error pulse.
// Ports: clk, reset (sync, active-high), bus (param_reg_file_if.slave).
// Optional: REG_ZERO_HARDWIRED_EN makes entry 0 a constant zero with no storage.
module param_reg_file #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter int               ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             reset,
    param_reg_file_if.slave bus
);

`ifdef REG_ZERO_HARDWIRED_EN
    localparam int LO = 1;
`else
    localparam int LO = 0;
`endif

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LO_W    = (ADDR_WIDTH+1)'(LO);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] sweep_q;
    logic                  ready_q;
    logic                  err_q;
    logic [WIDTH-1:0]      rd0_q;
    logic [WIDTH-1:0]      rd1_q;
    logic [WIDTH-1:0]      mem_q [LO:DEPTH-1];

    logic addr_ok;
    logic wr_legal;
    logic wr_store;
    logic wr_err;
    logic sweep_we;

    always_comb begin
        addr_ok  = {1'b0, bus.write_address} < DEPTH_W;
        wr_legal = bus.write_enable && (state_q == S_READY)
                   && !bus.clear && addr_ok;
        // A legal write to a hardwired entry is dropped silently
        wr_store = wr_legal && ({1'b0, bus.write_address} >= LO_W);
        wr_err   = bus.write_enable
                   && ((state_q != S_READY) || bus.clear || !addr_ok);
        sweep_we = !reset && !bus.clear && (state_q == S_INIT);
    end

    // Read value with bypass; unbacked or out-of-range addresses give 0
    function automatic logic [WIDTH-1:0] rd_val(
        input logic [ADDR_WIDTH-1:0] ra
    );
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = LO; i < DEPTH; i++) begin
            if (ra == ADDR_WIDTH'(i)) v = mem_q[i];
        end
        if (wr_store && (bus.write_address == ra)) v = bus.write_data;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            err_q <= wr_err;
            if (bus.clear) begin
                state_q <= S_INIT;
                sweep_q <= '0;
                ready_q <= 1'b0;
                rd0_q   <= '0;
                rd1_q   <= '0;
            end else if (state_q == S_INIT) begin
                rd0_q   <= '0;
                rd1_q   <= '0;
                sweep_q <= sweep_q + 1'b1;
                if (sweep_q == LAST) begin
                    state_q <= S_READY;
                    ready_q <= 1'b1;
                    sweep_q <= '0;
                end
            end else begin
                rd0_q <= rd_val(bus.read_address_0);
                rd1_q <= rd_val(bus.read_address_1);
            end
        end
    end

    // Storage is never reset; the sweep overwrites it
    always_ff @(posedge clk) begin
        for (int i = LO; i < DEPTH; i++) begin
            if (sweep_we && (sweep_q == ADDR_WIDTH'(i))) begin
                mem_q[i] <= INIT_VALUE;
            end else if (wr_store && (bus.write_address == ADDR_WIDTH'(i))) begin
                mem_q[i] <= bus.write_data;
            end
        end
    end

    assign bus.read_data_0 = rd0_q;
    assign bus.read_data_1 = rd1_q;
    assign bus.ready       = ready_q;
    assign bus.write_error = err_q;

endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: directed stimulus on a DEPTH=4 and a DEPTH=3 file,
// expected values queued with a due cycle and checked by a separate monitor.
module tb_param_reg_file;

    logic clk;
    logic reset;

    param_reg_file_if #(.WIDTH(8), .DEPTH(4)) ia ();
    param_reg_file_if #(.WIDTH(8), .DEPTH(3)) ib ();

    param_reg_file #(.WIDTH(8), .DEPTH(4), .INIT_VALUE(8'hA5)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (ia.slave)
    );

    param_reg_file #(.WIDTH(8), .DEPTH(3), .INIT_VALUE(8'hA5)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (ib.slave)
    );

`ifdef REG_ZERO_HARDWIRED_EN
    localparam logic [7:0] I0  = 8'h00;
    localparam logic [7:0] E01 = 8'h00;
    localparam logic [7:0] EFF = 8'h00;
`else
    localparam logic [7:0] I0  = 8'hA5;
    localparam logic [7:0] E01 = 8'h01;
    localparam logic [7:0] EFF = 8'hFF;
`endif

    localparam int A_RD0 = 0, A_RD1 = 1, A_RDY = 2, A_ERR = 3;
    localparam int B_RD0 = 4, B_RD1 = 5, B_RDY = 6, B_ERR = 7;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         q_due [$];
    int         q_sig [$];
    logic [7:0] q_val [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string nm(input int s);
        case (s)
            A_RD0:   return "a.read_data_0";
            A_RD1:   return "a.read_data_1";
            A_RDY:   return "a.ready";
            A_ERR:   return "a.write_error";
            B_RD0:   return "b.read_data_0";
            B_RD1:   return "b.read_data_1";
            B_RDY:   return "b.ready";
            default: return "b.write_error";
        endcase
    endfunction

    function automatic logic [7:0] get(input int s);
        case (s)
            A_RD0:   return ia.read_data_0;
            A_RD1:   return ia.read_data_1;
            A_RDY:   return {7'd0, ia.ready};
            A_ERR:   return {7'd0, ia.write_error};
            B_RD0:   return ib.read_data_0;
            B_RD1:   return ib.read_data_1;
            B_RDY:   return {7'd0, ib.ready};
            default: return {7'd0, ib.write_error};
        endcase
    endfunction

    // Monitor: outputs are sampled 1 time unit after each edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        while (q_due.size() != 0 && q_due[0] <= cyc) begin
            int         s;
            logic [7:0] e;
            logic [7:0] a;
            s = q_sig.pop_front();
            e = q_val.pop_front();
            void'(q_due.pop_front());
            a = get(s);
            n_chk = n_chk + 1;
            if (a !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL %s @cycle %0d: got %02h, expected %02h",
                         nm(s), cyc, a, e);
            end
        end
    end

    // Expectation for the outputs seen after the next rising edge
    task automatic exp(input int s, input logic [7:0] v);
        q_due.push_back(cyc + 1);
        q_sig.push_back(s);
        q_val.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        ia.clear = 0; ia.write_enable = 0; ia.write_address = '0;
        ia.write_data = '0; ia.read_address_0 = '0; ia.read_address_1 = '0;
        ib.clear = 0; ib.write_enable = 0; ib.write_address = '0;
        ib.write_data = '0; ib.read_address_0 = '0; ib.read_address_1 = '0;

        // reset state
        exp(A_RDY, 0); exp(A_RD0, 0); exp(A_RD1, 0); exp(A_ERR, 0);
        exp(B_RDY, 0); exp(B_ERR, 0);
        step();

        // init sweep; write to b during INIT is rejected
        reset = 1'b0;
        ib.write_enable = 1; ib.write_address = 2'd1; ib.write_data = 8'h77;
        exp(A_RDY, 0); exp(A_RD0, 0); exp(B_RDY, 0); exp(B_ERR, 1);
        step();
        ib.write_enable = 0;
        exp(A_RDY, 0); exp(B_RDY, 0); exp(B_ERR, 0);
        step();
        exp(A_RDY, 0); exp(B_RDY, 1);
        step();
        exp(A_RDY, 1);
        step();

        // all entries hold INIT_VALUE
        ia.read_address_0 = 2'd0; ia.read_address_1 = 2'd1;
        ib.read_address_0 = 2'd1; ib.read_address_1 = 2'd2;
        exp(A_RD0, I0); exp(A_RD1, 8'hA5); exp(B_RD0, 8'hA5); exp(B_RD1, 8'hA5);
        step();
        ia.read_address_0 = 2'd2; ia.read_address_1 = 2'd3;
        ib.read_address_0 = 2'd0; ib.read_address_1 = 2'd3;
        exp(A_RD0, 8'hA5); exp(A_RD1, 8'hA5); exp(B_RD0, I0); exp(B_RD1, 8'h00);
        step();

        // basic writes on a; out-of-range write on b
        ia.write_enable = 1; ia.write_address = 2'd0; ia.write_data = 8'h01;
        ib.write_enable = 1; ib.write_address = 2'd3; ib.write_data = 8'h77;
        exp(A_ERR, 0); exp(B_ERR, 1);
        step();
        ia.write_address = 2'd1; ia.write_data = 8'h0F;
        ib.write_enable = 0;
        ib.read_address_0 = 2'd1; ib.read_address_1 = 2'd2;
        exp(B_ERR, 0); exp(B_RD0, 8'hA5); exp(B_RD1, 8'hA5);
        step();
        ia.write_address = 2'd2; ia.write_data = 8'hFF;
        ib.read_address_0 = 2'd0; ib.read_address_1 = 2'd3;
        exp(B_RD0, I0); exp(B_RD1, 8'h00); exp(B_ERR, 0);
        step();
        ia.write_enable = 0;
        ia.read_address_0 = 2'd0; ia.read_address_1 = 2'd0;
        exp(A_RD0, E01); exp(A_RD1, E01);
        step();
        ia.read_address_0 = 2'd1; ia.read_address_1 = 2'd2;
        exp(A_RD0, 8'h0F); exp(A_RD1, 8'hFF);
        step();
        ia.read_address_0 = 2'd3; ia.read_address_1 = 2'd2;
        exp(A_RD0, 8'hA5); exp(A_RD1, 8'hFF);
        step();

        // bypass on port 0, old value on port 1
        ia.write_enable = 1; ia.write_address = 2'd2; ia.write_data = 8'h3C;
        ia.read_address_0 = 2'd2; ia.read_address_1 = 2'd1;
        exp(A_RD0, 8'h3C); exp(A_RD1, 8'h0F);
        step();
        ia.write_enable = 0;
        ia.read_address_0 = 2'd2; ia.read_address_1 = 2'd2;
        exp(A_RD0, 8'h3C); exp(A_RD1, 8'h3C);
        step();

        // clear together with a write
        ia.clear = 1;
        ia.write_enable = 1; ia.write_address = 2'd1; ia.write_data = 8'h55;
        exp(A_RDY, 0); exp(A_ERR, 1);
        step();
        ia.clear = 0; ia.write_enable = 0;
        exp(A_RDY, 0); exp(A_ERR, 0); exp(A_RD0, 0);
        step();
        exp(A_RDY, 0);
        step();
        exp(A_RDY, 0);
        step();
        exp(A_RDY, 1);
        step();
        ia.read_address_0 = 2'd0; ia.read_address_1 = 2'd1;
        exp(A_RD0, I0); exp(A_RD1, 8'hA5);
        step();
        ia.read_address_0 = 2'd2; ia.read_address_1 = 2'd3;
        exp(A_RD0, 8'hA5); exp(A_RD1, 8'hA5);
        step();

        // address 0 write (hardwired when the option is built)
        ia.write_enable = 1; ia.write_address = 2'd0; ia.write_data = 8'hFF;
        ia.read_address_0 = 2'd0;
        exp(A_ERR, 0); exp(A_RD0, EFF);
        step();
        ia.write_address = 2'd1; ia.write_data = 8'h5A;
        ia.read_address_1 = 2'd1;
        exp(A_ERR, 0); exp(A_RD0, EFF); exp(A_RD1, 8'h5A);
        step();
        ia.write_enable = 0;
        exp(A_RD0, EFF); exp(A_RD1, 8'h5A); exp(A_ERR, 0);
        step();
        step();
        step();

        if (q_due.size() != 0) begin
            n_chk = n_chk + 1;
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d pending, expected 0", q_due.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
- Parametrised register file with DEPTH entries of WIDTH bits, one synchronous write port and two addressed, registered read ports.
- Replaces fixed three-entry files that expose every register on its own output.
- Adds the following over fixed files:
  - an init sweep after reset or clear, which fills every entry with INIT_VALUE, one entry per cycle;
  - a ready flag;
  - write-to-read bypass;
  - write error reporting.
- Sits between datapath producers (write side) and consumers (read side) inside a single clock domain.

Parameters:
- WIDTH, 8, data width of each entry.
- DEPTH, 4, number of entries. DEPTH >= 2; DEPTH does not need to be a power of two.
- INIT_VALUE, 0, value written to every entry during the init sweep. Truncated to WIDTH bits.
- ADDR_WIDTH, $clog2(DEPTH), address width. Derived; do not override.

Ports:
- clk  input  1  clock, all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  restarts the init sweep without a reset.
- write_enable  input  1  write request, qualified by ready.
- write_address  input  ADDR_WIDTH  write target entry.
- write_data  input  WIDTH  write data.
- read_address_0  input  ADDR_WIDTH  read port 0 address.
- read_address_1  input  ADDR_WIDTH  read port 1 address.
- read_data_0  output  WIDTH  registered read port 0 data.
- read_data_1  output  WIDTH  registered read port 1 data.
- ready  output  1  high when in READY state and accepting writes.
- write_error  output  1  one-cycle registered pulse flagging a rejected write.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- On reset, all of the following take effect at the next edge:
  - state = INIT, sweep_ptr = 0;
  - ready = 0, read_data_0 = 0, read_data_1 = 0, write_error = 0.
- Storage contents are not cleared by reset directly; the init sweep overwrites them.
- INIT state:
  - Each edge writes INIT_VALUE to mem[sweep_ptr], then sweep_ptr increments.
  - The edge that writes entry DEPTH-1 moves the state to READY and sets ready = 1.
  - First edge with reset low writes entry 0; ready is high after the DEPTH-th such edge.
  - read_data_x is held at 0.
- READY state, write:
  - A legal write is write_enable=1 with write_address < DEPTH.
  - A legal write updates mem[write_address] at the edge.
- READY state, read (latency 1):
  - Each edge loads read_data_x from mem[read_address_x].
  - Bypass: if a legal write targets read_address_x in the same cycle, read_data_x loads write_data instead of the old contents.
  - Both ports may read the same address.
  - read_address_x >= DEPTH loads 0.
- write_error is set to 1 for exactly one cycle, one edge after any of these:
  - write_enable=1 while not READY (INIT, or the cycle in which clear is sampled);
  - write_enable=1 with write_address >= DEPTH.
  - A rejected write never modifies storage.
- clear:
  - clear=1 at an edge moves the state to INIT, sets sweep_ptr=0 and drops ready.
  - Applies in any state; clear during INIT restarts the sweep from 0.
  - Priority: reset > clear > write.
- reset during INIT restarts the sweep from 0.
- Simultaneous events:
  - Simultaneous write and reads are allowed.
  - Reads observe the new data through the bypass.
  - Storage holds the new data from the following cycle.

Optional Feature:
- Macro: REG_ZERO_HARDWIRED_EN.
- Defined:
  - entry 0 always reads 0 and no storage is built for it;
  - the init sweep skips writing it;
  - writes to address 0 are silently discarded, with no write_error and no bypass;
  - reads of address 0 load 0.
- Undefined: entry 0 is an ordinary entry.

Test Plan:
- Init sweep: WIDTH=8, DEPTH=4, INIT_VALUE=8'hA5. Assert reset for 1 cycle, then release -> ready rises 4 edges later, not earlier. All four addresses then read 8'hA5 one cycle after the address is applied.
- Basic writes: write 8'h01 to address 0, 8'h0F to 1, 8'hFF to 2, each with a 1-cycle write_enable pulse -> port 0 and port 1 read back 01, 0F and FF. Address 3 still reads A5.
- Bypass: read_address_0 = 2 while writing 8'h3C to 2 -> read_data_0 = 8'h3C on the next edge. read_address_1 = 1 in the same cycle returns the old value, 8'h0F.
- Errors: DEPTH=3, write address 3 with data 8'h77 -> write_error high for exactly 1 cycle. Entries 0–2 unchanged; reading address 3 returns 0. A write during INIT also pulses write_error and is lost.
- Clear mid-operation: pulse clear together with a write of 8'h55 to address 1 -> ready drops and write_error pulses. ready returns DEPTH edges later, and every entry reads INIT_VALUE, not 8'h55.
- Macro build with REG_ZERO_HARDWIRED_EN: write 8'hFF to address 0 -> read_data returns 8'h00 and write_error stays low. Address 1 behaves normally.
